// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with a per-entry busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy to the read side.
module regfile_scoreboard #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              srst_n,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   input  logic              rd_en,
   input  logic              write,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              set_busy,
   input  logic [ADDR_W-1:0] busy_addr,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic [DATA_W-1:0] sw_data,
   output logic              busy1,
   output logic              busy2,
   output logic              hazard
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [DATA_W-1:0] rdata1_q, rdata2_q;
   logic              busy1_q, busy2_q;

   logic              wr_ok, set_ok;
   logic [DATA_W-1:0] rv1, rv2;
   logic              rb1, rb2;

   assign wr_ok  = write    && !(ZERO_REG != 0 && waddr     == '0);
   assign set_ok = set_busy && !(ZERO_REG != 0 && busy_addr == '0);

   // Read-side view of the array, shared by the registered ports and sw_data/hazard.
   always_comb begin
      rv1 = mem_q[raddr1];
      rv2 = mem_q[raddr2];
      rb1 = busy_q[raddr1];
      rb2 = busy_q[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && waddr == raddr1) begin
         rv1 = wdata;
         rb1 = set_ok && busy_addr == raddr1;
      end
      if (wr_ok && waddr == raddr2) begin
         rv2 = wdata;
         rb2 = set_ok && busy_addr == raddr2;
      end
`endif
      if (ZERO_REG != 0 && raddr1 == '0) begin
         rv1 = '0;
         rb1 = 1'b0;
      end
      if (ZERO_REG != 0 && raddr2 == '0) begin
         rv2 = '0;
         rb2 = 1'b0;
      end
   end

   // Clear first, then set: a same-edge set_busy marks the newer producer.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok)  busy_d[waddr]     = 1'b0;
      if (set_ok) busy_d[busy_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         busy_q   <= '0;
         rdata1_q <= '0;
         rdata2_q <= '0;
         busy1_q  <= 1'b0;
         busy2_q  <= 1'b0;
      end else begin
         if (wr_ok) mem_q[waddr] <= wdata;
         busy_q <= busy_d;
         if (rd_en) begin
            rdata1_q <= rv1;
            rdata2_q <= rv2;
            busy1_q  <= rb1;
            busy2_q  <= rb2;
         end
      end
   end

   // Gate on reset so a forwarded write cannot leak out while the array is held clear.
   assign sw_data = srst_n ? rv2 : '0;
   assign hazard  = srst_n && (rb1 || rb2);

   assign rdata1 = rdata1_q;
   assign rdata2 = rdata2_q;
   assign busy1  = busy1_q;
   assign busy2  = busy2_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed table, corner sequences, random vs. model.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk, srst_n;
   logic [4:0]  raddr1, raddr2, waddr, busy_addr;
   logic        rd_en, write, set_busy;
   logic [31:0] wdata, rdata1, rdata2, sw_data;
   logic        busy1, busy2, hazard;

   int n_chk = 0;
   int n_fail = 0;

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
      .clk(clk), .srst_n(srst_n), .raddr1(raddr1), .raddr2(raddr2), .rd_en(rd_en),
      .write(write), .waddr(waddr), .wdata(wdata), .set_busy(set_busy),
      .busy_addr(busy_addr), .rdata1(rdata1), .rdata2(rdata2), .sw_data(sw_data),
      .busy1(busy1), .busy2(busy2), .hazard(hazard)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                        input logic sb, input logic [4:0] ba,
                        input logic [4:0] r1, input logic [4:0] r2, input logic re);
      @(negedge clk);
      write = wr; waddr = wa; wdata = wd; set_busy = sb; busy_addr = ba;
      raddr1 = r1; raddr2 = r2; rd_en = re;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic wr; logic [4:0] wa; logic [31:0] wd; logic sb; logic [4:0] ba;
      logic [4:0] r1; logic [4:0] r2; logic re;
      logic e_haz; logic [31:0] e_sw; logic [31:0] e_rd1; logic [31:0] e_rd2;
      logic e_b1; logic e_b2;
   } vec_t;

   vec_t vt[10];

   // Behavioural reference: array contents, busy flags, captured outputs.
   logic [31:0] m_mem [32];
   logic        m_busy[32];
   logic [31:0] m_r1, m_r2;
   logic        m_b1, m_b2;

   function automatic logic [31:0] view_d(input logic [4:0] a, input logic wr,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (a == 0) return 32'h0;
      if (BYP && wr && wa == a) return wd;
      return m_mem[a];
   endfunction

   function automatic logic view_b(input logic [4:0] a, input logic wr, input logic [4:0] wa,
                                   input logic sb, input logic [4:0] ba);
      if (a == 0) return 1'b0;
      if (BYP && wr && wa == a) return sb && ba == a;
      return m_busy[a];
   endfunction

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 5));
   endfunction

   initial begin
      vt[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
      vt[2] = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
      vt[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      vt[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
      vt[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1};
      vt[6] = '{1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 5'd7, 5'd1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1};
      vt[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 32'hA5, 32'hA5, 32'hA5, 1'b0, 1'b0};
      vt[8] = '{1'b1, 5'd5, 32'hB6, 1'b1, 5'd5, 5'd7, 5'd1, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
      vt[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd5, 1'b1, 1'b1, 32'hB6, 32'h0, 32'hB6, 1'b0, 1'b1};

      write = 0; waddr = 0; wdata = 0; set_busy = 0; busy_addr = 0;
      raddr1 = 0; raddr2 = 0; rd_en = 0;
      srst_n = 1'b0;
      #1;
      check("reset_rdata1", rdata1, 32'h0);
      check("reset_busy1", {31'b0, busy1}, 32'h0);
      check("reset_hazard", {31'b0, hazard}, 32'h0);
      #11 srst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         drive(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].sb, vt[i].ba, vt[i].r1, vt[i].r2, vt[i].re);
         check($sformatf("tbl%0d_hazard", i), {31'b0, hazard}, {31'b0, vt[i].e_haz});
         check($sformatf("tbl%0d_sw_data", i), sw_data, vt[i].e_sw);
         tick();
         check($sformatf("tbl%0d_rdata1", i), rdata1, vt[i].e_rd1);
         check($sformatf("tbl%0d_rdata2", i), rdata2, vt[i].e_rd2);
         check($sformatf("tbl%0d_busy1", i), {31'b0, busy1}, {31'b0, vt[i].e_b1});
         check($sformatf("tbl%0d_busy2", i), {31'b0, busy2}, {31'b0, vt[i].e_b2});
      end

      // Same-cycle read/write on entry 3, then rd_en hold.
      drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0);
      tick();
      drive(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 5'd3, 5'd3, 1'b1);
      check("rw3_sw_data", sw_data, BYP ? 32'h22 : 32'h11);
      tick();
      check("rw3_rdata1", rdata1, BYP ? 32'h22 : 32'h11);
      check("rw3_rdata2", rdata2, BYP ? 32'h22 : 32'h11);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 1'b1);
      tick();
      check("cap3_rdata1", rdata1, 32'h22);
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3, 5'd3, 1'b0);
      tick();
      check("hold_rdata1", rdata1, 32'h22);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd5, 1'b1);
      check("pre_rst_hazard", {31'b0, hazard}, 32'h1);
      tick();
      check("pre_rst_rdata1", rdata1, 32'h33);
      check("pre_rst_busy2", {31'b0, busy2}, 32'h1);

      // Reset between edges with a write and set_busy in flight.
      @(negedge clk);
      write = 1'b1; waddr = 5'd10; wdata = 32'hBAD; set_busy = 1'b1; busy_addr = 5'd10;
      srst_n = 1'b0;
      #1;
      check("rst_rdata1", rdata1, 32'h0);
      check("rst_rdata2", rdata2, 32'h0);
      check("rst_busy1", {31'b0, busy1}, 32'h0);
      check("rst_busy2", {31'b0, busy2}, 32'h0);
      check("rst_hazard", {31'b0, hazard}, 32'h0);
      check("rst_sw_data", sw_data, 32'h0);
      tick();
      write = 1'b0; set_busy = 1'b0;
      srst_n = 1'b1;
      drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(a), 1'b1);
         check($sformatf("post_rst_sw%0d", a), sw_data, (a == 9) ? 32'h99 : 32'h0);
         check($sformatf("post_rst_haz%0d", a), {31'b0, hazard}, 32'h0);
         tick();
         check($sformatf("post_rst_rd%0d", a), rdata1, (a == 9) ? 32'h99 : 32'h0);
      end

      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = (i == 9) ? 32'h99 : 32'h0;
         m_busy[i] = 1'b0;
      end
      m_r1 = 32'h0; m_r2 = 32'h0; m_b1 = 1'b0; m_b2 = 1'b0;

      for (int n = 0; n < 500; n++) begin
         logic        wr, sb, re;
         logic [4:0]  wa, ba, r1, r2;
         logic [31:0] wd;
         wr = ($urandom_range(0, 1) == 1);
         sb = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 3) != 0);
         wa = rnd_addr(); ba = rnd_addr(); r1 = rnd_addr(); r2 = rnd_addr();
         wd = $urandom;
         drive(wr, wa, wd, sb, ba, r1, r2, re);
         check("rnd_sw_data", sw_data, view_d(r2, wr, wa, wd));
         check("rnd_hazard", {31'b0, hazard},
               {31'b0, view_b(r1, wr, wa, sb, ba) || view_b(r2, wr, wa, sb, ba)});
         if (re) begin
            m_r1 = view_d(r1, wr, wa, wd);
            m_r2 = view_d(r2, wr, wa, wd);
            m_b1 = view_b(r1, wr, wa, sb, ba);
            m_b2 = view_b(r2, wr, wa, sb, ba);
         end
         if (wr && wa != 0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
         end
         if (sb && ba != 0) m_busy[ba] = 1'b1;
         tick();
         check("rnd_rdata1", rdata1, m_r1);
         check("rnd_rdata2", rdata2, m_r2);
         check("rnd_busy1", {31'b0, busy1}, {31'b0, m_b1});
         check("rnd_busy2", {31'b0, busy2}, {31'b0, m_b2});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of every entry and data port.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2^ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 = entry 0 is hardwired zero.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port srst_n  input  1: reset, asynchronous assert and active-low.
REQ-006 SHALL have port raddr1  input  ADDR_W: read port 1 address.
REQ-007 SHALL have port raddr2  input  ADDR_W: read port 2 address.
REQ-008 SHALL have port rd_en  input  1: capture enable for rdata1/rdata2/busy1/busy2.
REQ-009 SHALL have port write  input  1: write enable.
REQ-010 SHALL have port waddr  input  ADDR_W: write address.
REQ-011 SHALL have port wdata  input  DATA_W: write data.
REQ-012 SHALL have port set_busy  input  1: mark entry busy_addr as pending a write.
REQ-013 SHALL have port busy_addr  input  ADDR_W: entry marked by set_busy.
REQ-014 SHALL have port rdata1  output  DATA_W: registered read data, port 1.
REQ-015 SHALL have port rdata2  output  DATA_W: registered read data, port 2.
REQ-016 SHALL have port sw_data  output  DATA_W: combinational read of entry raddr2 (store-data path).
REQ-017 SHALL have port busy1  output  1: registered busy bit of raddr1, captured with rdata1.
REQ-018 SHALL have port busy2  output  1: registered busy bit of raddr2, captured with rdata2.
REQ-019 SHALL have port hazard  output  1: combinational OR of current busy bits of raddr1 and raddr2.

Function
REQ-020 SHALL, on a clk edge with write=1, load wdata into entry waddr; all other entries hold.
REQ-021 SHALL, with ZERO_REG=1, ignore writes to entry 0, read entry 0 as 0 on all ports, never set its busy bit.
REQ-022 SHALL, on a clk edge with rd_en=1, load rdata1/rdata2 from entries raddr1/raddr2 (1-cycle latency); with rd_en=0, hold rdata1, rdata2, busy1, busy2.
REQ-023 SHALL keep one busy bit per entry: set on an edge with set_busy=1 at busy_addr, cleared on an edge with write=1 at waddr.
REQ-024 SHALL, when set_busy and write target the same entry on the same edge, leave it busy (set wins; newer producer).
REQ-025 SHALL capture busy1/busy2 on rd_en edges from the busy bits as they stand before that edge's update (subject to REQ-034).
REQ-026 SHALL drive hazard and sw_data from current state only, with no dependence on write/wdata in the same cycle (subject to REQ-034).
REQ-027 SHALL allow raddr1 == raddr2; both ports return identical data.
REQ-028 SHALL wrap nothing: every address in 0..2^ADDR_W-1 is valid; no out-of-range case exists.

Reset
REQ-029 SHALL, while srst_n=0, immediately clear every entry, every busy bit, rdata1, rdata2, busy1, busy2, independent of clk.
REQ-030 SHALL drive sw_data=0 and hazard=0 during reset.
REQ-031 SHALL, on reset mid-operation, discard any write or set_busy in flight; the first write is accepted on the first rising edge with srst_n=1.

Configuration
REQ-032 SHALL provide the macro REGFILE_BYPASS_EN, controlling write-to-read forwarding.
REQ-033 SHALL, without REGFILE_BYPASS_EN, return old contents and old busy bit to rdata/busy/sw_data/hazard when read and write hit the same entry in the same cycle.
REQ-034 SHALL, with REGFILE_BYPASS_EN, forward wdata (and busy=0, unless set_busy hits the same entry) to rdata1/rdata2/busy1/busy2 on a same-edge read/write address match, and to sw_data/hazard combinationally; this never applies to entry 0 when ZERO_REG=1.

Verification
REQ-035 SHALL check reset: preload entries, assert srst_n=0 between edges -> rdata1/rdata2=0, busy1/busy2=0, hazard=0 at once; all entries read 0 afterwards.
REQ-036 SHALL check basic write/read: write 0xDEADBEEF to entry 7; next cycle raddr1=7, rd_en=1 -> rdata1=0xDEADBEEF one edge later.
REQ-037 SHALL check zero entry: write 0x12345678 to entry 0, set_busy at 0 -> rdata1=0, sw_data=0, hazard=0.
REQ-038 SHALL check scoreboard: set_busy at 5; raddr2=5 -> hazard=1; write 0xA5 to 5 -> hazard=0 next cycle; same-edge set_busy and write at 5 -> entry stays busy.
REQ-039 SHALL check same-cycle read/write at entry 3 (old 0x11, new 0x22): no macro -> rdata1=0x11; REGFILE_BYPASS_EN -> rdata1=0x22, sw_data=0x22 before the edge.
REQ-040 SHALL check rd_en hold: capture 0x22, then rd_en=0 and write 0x33 to entry 3 -> rdata1 remains 0x22.
